// File: rtl/spectrum_bar_display.sv
// Spectrum bar display: captures eight band magnitudes, applies bar decay and
// peak-hold ballistics, and scans the result onto an 8x8 LED matrix.
module spectrum_bar_display #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DECAY_DIV  = 50000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spectrum_valid,
    input  logic [7:0] spectrum_0,
    input  logic [7:0] spectrum_1,
    input  logic [7:0] spectrum_2,
    input  logic [7:0] spectrum_3,
    input  logic [7:0] spectrum_4,
    input  logic [7:0] spectrum_5,
    input  logic [7:0] spectrum_6,
    input  logic [7:0] spectrum_7,
    output logic [7:0] led_col,
    output logic [7:0] led_row,
    output logic       peak_any_full
);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DECAY_DIV);

    logic [7:0]    spec [8];
    logic [3:0]    lvl [8];
    logic [3:0]    bar_q [8];
    logic [3:0]    bar_d [8];
    logic [3:0]    peak_q [8];
    logic [3:0]    peak_d [8];
    logic [3:0]    hold_q [8];
    logic [3:0]    hold_d [8];
    logic [SW-1:0] scnt_q;
    logic [DW-1:0] dcnt_q;
    logic [2:0]    col_q;
    logic          tick;
    logic [7:0]    row_d;
    logic          paf_d;

    always_comb begin
        spec[0] = spectrum_0;
        spec[1] = spectrum_1;
        spec[2] = spectrum_2;
        spec[3] = spectrum_3;
        spec[4] = spectrum_4;
        spec[5] = spectrum_5;
        spec[6] = spectrum_6;
        spec[7] = spectrum_7;
    end

    assign tick = (dcnt_q == DW'(DECAY_DIV - 1));

    // Peak decay compares against the bar's next value so peak >= bar always holds.
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            lvl[k]    = (spec[k] == 8'd0) ? 4'd0 : ({1'b0, spec[k][7:5]} + 4'd1);
            bar_d[k]  = bar_q[k];
            peak_d[k] = peak_q[k];
            hold_d[k] = hold_q[k];
            if (spectrum_valid && (lvl[k] >= bar_q[k])) begin
                bar_d[k] = lvl[k];
            end else if (tick && (bar_q[k] != 4'd0)) begin
                bar_d[k] = bar_q[k] - 4'd1;
            end
            if (spectrum_valid && (lvl[k] >= peak_q[k])) begin
                peak_d[k] = lvl[k];
                hold_d[k] = 4'(HOLD_TICKS);
            end else if (tick) begin
                if (hold_q[k] != 4'd0) begin
                    hold_d[k] = hold_q[k] - 4'd1;
                end else if (peak_q[k] > bar_d[k]) begin
                    peak_d[k] = peak_q[k] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        row_d = '0;
        paf_d = 1'b0;
        for (int unsigned r = 0; r < 8; r++) begin
            row_d[r] = (4'(r) < bar_q[col_q]) |
                       ((peak_q[col_q] != 4'd0) && (4'(r) == peak_q[col_q] - 4'd1));
        end
        for (int unsigned k = 0; k < 8; k++) begin
            paf_d = paf_d | (peak_q[k] == 4'd8);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q        <= '0;
            dcnt_q        <= '0;
            col_q         <= '0;
            led_col       <= 8'h01;
            led_row       <= '0;
            peak_any_full <= 1'b0;
            for (int unsigned k = 0; k < 8; k++) begin
                bar_q[k]  <= '0;
                peak_q[k] <= '0;
                hold_q[k] <= '0;
            end
        end else begin
            if (scnt_q == SW'(SCAN_DIV - 1)) begin
                scnt_q <= '0;
                col_q  <= col_q + 3'd1;
            end else begin
                scnt_q <= scnt_q + SW'(1);
            end
            dcnt_q        <= tick ? '0 : dcnt_q + DW'(1);
            led_col       <= 8'b1 << col_q;
            led_row       <= row_d;
            peak_any_full <= paf_d;
            for (int unsigned k = 0; k < 8; k++) begin
                bar_q[k]  <= bar_d[k];
                peak_q[k] <= peak_d[k];
                hold_q[k] <= hold_d[k];
            end
        end
    end
endmodule

// File: tb/tb_spectrum_bar_display.sv
// Randomised self-checking bench for spectrum_bar_display against a
// time-indexed behavioural model of bar/peak ballistics and column scanning.
module tb_spectrum_bar_display;
    localparam int SCAN  = 4;
    localparam int DECAY = 8;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] s [8];
    logic [7:0] led_col;
    logic [7:0] led_row;
    logic       peak_any_full;

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset drive both scan position and decay ticks.
    int m_bar [8];
    int m_peak [8];
    int m_hold [8];
    int ecount;
    int e_col, e_row, e_paf, e_colidx;

    spectrum_bar_display #(
        .SCAN_DIV  (SCAN),
        .DECAY_DIV (DECAY),
        .HOLD_TICKS(HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spectrum_valid(valid),
        .spectrum_0    (s[0]),
        .spectrum_1    (s[1]),
        .spectrum_2    (s[2]),
        .spectrum_3    (s[3]),
        .spectrum_4    (s[4]),
        .spectrum_5    (s[5]),
        .spectrum_6    (s[6]),
        .spectrum_7    (s[7]),
        .led_col       (led_col),
        .led_row       (led_row),
        .peak_any_full (peak_any_full)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int quant(input int v);
        return (v == 0) ? 0 : v / 32 + 1;
    endfunction

    // Advance model by one edge using the inputs currently driven, then compare.
    task automatic cyc();
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_bar[k] = 0; m_peak[k] = 0; m_hold[k] = 0;
            end
            ecount = 0; e_col = 1; e_row = 0; e_paf = 0; e_colidx = 0;
        end else begin
            int c, lv, nb;
            bit t;
            c = (ecount / SCAN) % 8;
            t = (ecount % DECAY) == DECAY - 1;
            e_colidx = c;
            e_col = 1 << c;
            e_row = 0;
            for (int r = 0; r < 8; r++)
                if (r < m_bar[c] || (m_peak[c] != 0 && r == m_peak[c] - 1)) e_row += (1 << r);
            e_paf = 0;
            for (int k = 0; k < 8; k++) if (m_peak[k] == 8) e_paf = 1;
            for (int k = 0; k < 8; k++) begin
                lv = quant(int'(s[k]));
                nb = m_bar[k];
                if (valid && lv >= m_bar[k]) nb = lv;
                else if (t && m_bar[k] > 0) nb = m_bar[k] - 1;
                if (valid && lv >= m_peak[k]) begin
                    m_peak[k] = lv; m_hold[k] = HOLD;
                end else if (t) begin
                    if (m_hold[k] > 0) m_hold[k]--;
                    else if (m_peak[k] > nb) m_peak[k]--;
                end
                m_bar[k] = nb;
            end
            ecount++;
        end
        @(posedge clk);
        #1;
        check("led_col", int'(led_col), e_col);
        check("led_row", int'(led_row), e_row);
        check("peak_any_full", int'(peak_any_full), e_paf);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("bar%0d", k), int'(dut.bar_q[k]), m_bar[k]);
            check($sformatf("peak%0d", k), int'(dut.peak_q[k]), m_peak[k]);
            check($sformatf("hold%0d", k), int'(dut.hold_q[k]), m_hold[k]);
        end
    endtask

    task automatic clear_bands();
        for (int k = 0; k < 8; k++) s[k] = 8'd0;
    endtask

    task automatic rand_bands();
        for (int k = 0; k < 8; k++) s[k] = 8'($urandom_range(1, 255));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    int qin  [8] = '{0, 1, 31, 32, 128, 223, 224, 255};
    int qlvl [8] = '{0, 1, 1, 2, 5, 7, 8, 8};
    int qrow [8] = '{'h00, 'h01, 'h01, 'h03, 'h1F, 'h7F, 'hFF, 'hFF};

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        clear_bands();
        do_reset(2);

        // Reset mid-scan after loading data; valid is ignored while in reset.
        rand_bands();
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        repeat (6) cyc();
        rst = 1'b1;
        valid = 1'b1;
        repeat (3) cyc();
        check("rst_col", int'(led_col), 'h01);
        check("rst_row", int'(led_row), 'h00);
        check("rst_paf", int'(peak_any_full), 0);
        rst = 1'b0;
        valid = 1'b0;
        repeat (10) cyc();

        // Quantisation, data held valid for a whole frame so nothing decays.
        do_reset(1);
        for (int k = 0; k < 8; k++) s[k] = 8'(qin[k]);
        valid = 1'b1;
        for (int n = 0; n < 36; n++) begin
            cyc();
            if (n >= 2) check("quant_row", int'(led_row), qrow[e_colidx]);
        end
        valid = 1'b0;
        for (int k = 0; k < 8; k++) check("quant_lvl", int'(dut.bar_q[k]), qlvl[k]);
        check("quant_paf", int'(peak_any_full), 1);

        // Decay and peak hold on band 0.
        do_reset(1);
        clear_bands();
        s[0] = 8'd255;
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        clear_bands();
        for (int n = 0; n < 120; n++) begin
            cyc();
            check("peak_ge_bar", int'(dut.peak_q[0] >= dut.bar_q[0]), 1);
        end
        check("decay_bar_end", int'(dut.bar_q[0]), 0);
        check("decay_peak_end", int'(dut.peak_q[0]), 0);
        check("decay_row_end", int'(led_row), 0);

        // Valid landing on a decay tick.
        do_reset(1);
        clear_bands();
        s[0] = 8'd80;
        s[1] = 8'd80;
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        repeat (6) cyc();
        s[0] = 8'd100;
        s[1] = 8'd10;
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        check("sim_bar0", int'(dut.bar_q[0]), 4);
        check("sim_bar1", int'(dut.bar_q[1]), 2);
        repeat (20) cyc();

        // Scan wrap and dwell length.
        do_reset(1);
        clear_bands();
        begin
            logic [7:0] prev;
            int run;
            bit seen;
            prev = led_col;
            run = 0;
            seen = 0;
            for (int n = 0; n < 44; n++) begin
                cyc();
                if (led_col == prev) run++;
                else begin
                    check("col_seq", int'(led_col), int'({prev[6:0], prev[7]}));
                    if (seen) check("dwell", run, SCAN);
                    seen = 1;
                    run = 1;
                    prev = led_col;
                end
            end
        end

        // Valid held high: no decay, hold stays reloaded.
        do_reset(1);
        rand_bands();
        valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc();
            for (int k = 0; k < 8; k++) begin
                check("held_hold", int'(dut.hold_q[k]), HOLD);
                check("held_bar", int'(dut.bar_q[k]), quant(int'(s[k])));
                check("held_peak", int'(dut.peak_q[k]), quant(int'(s[k])));
            end
        end
        valid = 1'b0;
        repeat (40) cyc();

        // Random traffic with sporadic resets.
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            valid = ($urandom_range(0, 5) == 0);
            if (valid) begin
                for (int k = 0; k < 8; k++)
                    s[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            end
            cyc();
        end
        rst = 1'b0;
        valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spectrum_bar_display.md
# spectrum_bar_display

Consumer end of the spectrum interface. Captures the eight 8-bit band magnitudes whenever `spectrum_valid` pulses and quantises each band to a 0–8 bar height. Applies falling-bar ballistics and a peak-hold dot per band, then time-multiplexes the result onto an 8×8 LED matrix, one column per band. It sits between the spectrum analyser core and the board's matrix pins.

## Interface
- `SCAN_DIV`, 1000: clocks per displayed column (≥2).
- `DECAY_DIV`, 50000: clocks per decay tick (≥2).
- `HOLD_TICKS`, 4: decay ticks a new peak is held before it starts falling (0–15).
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `spectrum_valid` in 1: band data valid. Normally a 1-cycle pulse; sampled every cycle.
- `spectrum_0` … `spectrum_7` in 8 each: band magnitudes, unsigned, band 0 = lowest frequency.
- `led_col` out 8: column select, one-hot, active-high. Bit k drives band k.
- `led_row` out 8: row data for the selected column, active-high. Bit 0 is the bottom row.
- `peak_any_full` out 1: high while any band's peak equals 8 (overload indicator).

## Operation
- **Quantise**, combinational, per band: `lvl = 0` if `s == 0`, else `(s >> 5) + 1`. Results: 1–31 → 1, 32–63 → 2, …, 224–255 → 8. Width is 4 bits, range 0–8.
- **Decay tick**: `dcnt` counts 0 to `DECAY_DIV-1` and wraps. `tick` is high during the cycle in which `dcnt == DECAY_DIV-1`.
- **Per band k**, registers are `bar[k]` (4b), `peak[k]` (4b) and `hold[k]` (4b). They update at each edge, in this priority:
  - If `spectrum_valid` and `lvl ≥ bar[k]`: `bar[k] ← lvl`.
  - Otherwise, if `tick` and `bar[k] > 0`: `bar[k] ← bar[k] − 1`.
  - If `spectrum_valid` and `lvl ≥ peak[k]`: `peak[k] ← lvl` and `hold[k] ← HOLD_TICKS`.
  - Otherwise, if `tick`: when `hold[k] > 0`, `hold[k] ← hold[k] − 1`; else when `peak[k] > next bar[k]`, `peak[k] ← peak[k] − 1`.
  - Invariant: `peak[k] ≥ bar[k]` at all times.
- A `valid` that coincides with a `tick` follows the priority above independently per band. A band that rises takes the new level and does not decay in that cycle; a band that does not rise decays.
- If `spectrum_valid` is held high for several cycles, each cycle recaptures the same data. This is idempotent, apart from reloading `hold`.
- **Scan**: `scnt` counts 0 to `SCAN_DIV-1`. At wrap, `col ← col + 1` modulo 8 (7 → 0).
- **Registered outputs**, every edge:
  - `led_col ← 1 << col`.
  - `led_row[r] ← (r < bar[col]) | (peak[col] != 0 & r == peak[col] − 1)`, using current register values.
  - `peak_any_full ← OR over k of (peak[k] == 8)`.
- **Reset**: bar, peak, hold, `dcnt`, `scnt` and `col` are all 0. Outputs are `led_col = 8'h01`, `led_row = 8'h00`, `peak_any_full = 0`.
  - A reset asserted mid-scan or mid-decay restarts everything the next edge.
  - `spectrum_valid` is ignored while `rst` is high.

## Timing
- **Capture latency**: data present with `spectrum_valid` at edge T is in `bar`/`peak` after T. It appears on `led_row` after edge T+1, provided that band's column is selected.
- **Column change**: `col` increments at the edge where `scnt == SCAN_DIV-1`. `led_col` and `led_row` switch together one edge later, so no mixed column/row data is ever driven.
- **Dwell**: each column is displayed for exactly `SCAN_DIV` cycles. A full frame takes `8·SCAN_DIV` cycles.
- **Bar decay**: 1 level per `DECAY_DIV` cycles.
- **Peak after a capture**: stays for exactly `HOLD_TICKS` ticks, then falls 1 level per tick until it meets the bar.
- **Overload flag**: `peak_any_full` lags the peak registers by 1 cycle.

## Test plan
Bench parameters: `SCAN_DIV = 4`, `DECAY_DIV = 8`, `HOLD_TICKS = 2`.

1. **Reset values**: assert `rst` for 3 cycles mid-scan, after loading data. Required: `led_col = 01`, `led_row = 00`, `peak_any_full = 0`, and the 4-cycle column dwell restarts from column 0.
2. **Quantisation**: pulse valid with bands = {0, 1, 31, 32, 128, 223, 224, 255}. Required levels {0, 1, 1, 2, 5, 7, 8, 8}. Check `led_row` per column: {00, 01, 01, 03, 1F, 7F, FF, FF}. `peak_any_full` must be 1.
3. **Decay and peak hold**, band 0 only = 255:
   - Bar must read 8, 7, 6 … on successive ticks.
   - The peak dot stays on row 7 for 2 ticks, then falls 1 per tick.
   - `peak[0] ≥ bar[0]` at every cycle.
   - Both reach 0 and `led_row = 00`.
4. **Simultaneous valid and tick**: bands = {100, 10} with bar = {3, 3}, valid landing on the tick cycle. Required: bar0 = 4 (rise wins), bar1 = 2 (decay).
5. **Scan wrap**: run 40 cycles. Required: `led_col` sequence 01, 02, 04 … 80, 01, each value held exactly 4 cycles.
6. **Held valid**: keep `spectrum_valid` high for 10 cycles with constant data. Required: bar and peak stay at the captured level with no decay, and `hold` stays at 2. Decay resumes on the first tick after valid falls.
